logic_arb: RTL and testbench
============================

LOGIC_ARB -- requirements
Module: logic_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port req  input  4  request per requester i (bit i).
REQ-005 The block SHALL have port op_a  input  4*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port op_b  input  4*WIDTH  operand B; same packing as op_a.
REQ-007 The block SHALL have port op_sel  input  8  opcode; requester i at bits [2i+1:2i].
REQ-008 The block SHALL have port gnt  output  4  one-hot grant, registered.
REQ-009 The block SHALL have port done  output  4  one-hot completion pulse, registered.
REQ-010 The block SHALL have port result  output  WIDTH  shared result bus, registered.
REQ-011 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL share one WIDTH-bit bitwise unit among four requesters; opcode 00 = a&b, 01 = a|b, 10 = a^b, 11 = ~(a&b).
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP; transitions: IDLE->EXEC when any req bit is high, EXEC->RESP always, RESP->IDLE always.
REQ-014 req, op_a, op_b and op_sel SHALL be sampled only in IDLE; the winner's operands and opcode are latched on the IDLE->EXEC edge, and later input changes have no effect on that transaction.
REQ-015 Arbitration SHALL be round-robin with a 2-bit pointer ptr; the winner is the first requesting index scanning ptr, ptr+1, ... mod 4.
REQ-016 ptr SHALL update to (winner+1) mod 4 on the IDLE->EXEC edge; ptr is unchanged while idle.
REQ-017 gnt[winner] SHALL be high during EXEC and RESP only; gnt SHALL be 0 in IDLE.
REQ-018 result SHALL be computed from the latched operands and registered on the EXEC->RESP edge; it SHALL hold its value until the next EXEC->RESP edge.
REQ-019 done[winner] SHALL be high for exactly one cycle, in RESP; all other done bits SHALL stay 0.
REQ-020 Latency SHALL be fixed: req sampled in cycle N, gnt high in N+1, done and result valid in N+2, IDLE again in N+3; throughput is one operation per 3 cycles.
REQ-021 A requester SHALL deassert req by the end of its done cycle; a req still high in the following IDLE is a new request.
REQ-022 Simultaneous requests SHALL each be served exactly once in pointer order; four constantly active requesters SHALL be served 0,1,2,3,0,... from reset.
REQ-023 A requester deasserting req before it is granted SHALL be ignored, with no grant and no done.
REQ-024 At most one gnt bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-025 Asserting rst SHALL force state IDLE, ptr = 0, gnt = 0, done = 0, result = 0 and busy = 0 immediately, without waiting for clk.
REQ-026 An rst asserted in EXEC or RESP SHALL abort the transaction with no done pulse; after release, arbitration restarts from ptr = 0.

Configuration
REQ-027 With macro LOGIC_ARB_STATS_EN defined, the block SHALL add output op_cnt (16 bits): completed-operation count, reset to 0, +1 per RESP cycle, saturating at 16'hFFFF.
REQ-028 Without LOGIC_ARB_STATS_EN, port op_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-029 req=0001, op_a[7:0]=F0, op_b[7:0]=3C, op_sel=00 -> gnt=0001 at N+1; done=0001 and result=30 at N+2; busy high N+1..N+2.
REQ-030 Opcodes 01/10/11 on requester 2 with A=F0, B=3C -> result FC, CC, CF respectively; done=0100 each.
REQ-031 req=1111 held, with each requester dropping req at its done -> grant order 0,1,2,3, three cycles apart; no done overlap.
REQ-032 After serving 1 (ptr=2), req=0011 -> requester 0 wins next; requester 1 follows.
REQ-033 rst pulsed during EXEC -> gnt, done and result 0 immediately; no done pulse; next req=1000 is served normally with ptr restarting at 0.
REQ-034 With LOGIC_ARB_STATS_EN, 5 operations -> op_cnt=5; with the counter preloaded to FFFF, one more operation -> op_cnt stays FFFF.

Source files
------------

// File: rtl/logic_arb.sv
// logic_arb: round-robin arbiter sharing one bitwise unit among four requesters; define LOGIC_ARB_STATS_EN to add the op_cnt completion counter
module logic_arb #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] op_a,
  input  logic [4*WIDTH-1:0] op_b,
  input  logic [7:0]         op_sel,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic [WIDTH-1:0]   result,
`ifdef LOGIC_ARB_STATS_EN
  output logic [15:0]        op_cnt,
`endif
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, win;
  logic [3:0] gnt_q, gnt_d, done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, alu;
  logic [1:0] sel_q, sel_d;
  logic go;
  assign go = (state_q == IDLE) && (|req);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state: one operation takes exactly IDLE->EXEC->RESP->IDLE
  always_comb
    state_d = go ? EXEC : (state_q == EXEC) ? RESP : IDLE;
  // winner is the first requester found scanning from ptr upward, wrapping mod 4
  always_comb begin
    win = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end
  // outputs and datapath next values; operands are captured only when a request is accepted
  always_comb begin
    alu      = (sel_q == 2'd0) ? (a_q & b_q) :
               (sel_q == 2'd1) ? (a_q | b_q) :
               (sel_q == 2'd2) ? (a_q ^ b_q) : ~(a_q & b_q);
    gnt_d    = (state_q == EXEC) ? gnt_q : go ? (4'b0001 << win) : 4'b0000;
    done_d   = (state_q == EXEC) ? gnt_q : 4'b0000;
    result_d = (state_q == EXEC) ? alu : result_q;
    ptr_d    = go ? win + 2'd1 : ptr_q;
    a_d      = go ? op_a[win*WIDTH +: WIDTH] : a_q;
    b_d      = go ? op_b[win*WIDTH +: WIDTH] : b_q;
    sel_d    = go ? op_sel[2*win +: 2] : sel_q;
  end
  // datapath and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
    end
  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = state_q != IDLE;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d;
  // completed operations, one per RESP cycle, saturating
  always_comb
    op_cnt_d = (state_q == RESP && op_cnt_q != 16'hFFFF) ? op_cnt_q + 16'd1 : op_cnt_q;
  // completion counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) op_cnt_q <= '0;
    else op_cnt_q <= op_cnt_d;
  assign op_cnt = op_cnt_q;
`endif
endmodule

// File: tb/tb_logic_arb.sv
// tb_logic_arb: scoreboard bench for logic_arb with a reference round-robin model
module tb_logic_arb;
  localparam int W = 8;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] req = '0;
  logic [4*W-1:0] op_a = '0, op_b = '0;
  logic [7:0] op_sel = '0;
  logic [3:0] gnt, done;
  logic [W-1:0] result;
  logic busy;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] op_cnt;
`endif
  int n_run = 0, n_fail = 0, n_ops = 0;
  logic [1:0] mptr = '0;
  logic [4+W-1:0] sb_q[$];
  logic [4+W-1:0] e;

  logic_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .gnt(gnt), .done(done), .result(result),
`ifdef LOGIC_ARB_STATS_EN
    .op_cnt(op_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
    return s == 2'd0 ? (a & b) : s == 2'd1 ? (a | b) : s == 2'd2 ? (a ^ b) : ~(a & b);
  endfunction

  always @(negedge clk) begin
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    chk("done_onehot", 32'($countones(done) <= 1), 32'd1);
    if (done !== 4'b0000) begin
      if (sb_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("done", 32'(done), 32'(e[4+W-1:W]));
        chk("result", 32'(result), 32'(e[W-1:0]));
      end
    end
  end

  task automatic issue(input logic [3:0] r, input logic [4*W-1:0] a, input logic [4*W-1:0] b, input logic [7:0] s);
    int w = -1;
    req = r; op_a = a; op_b = b; op_sel = s;
    for (int k = 0; k < 4; k++)
      if (w < 0 && r[(int'(mptr) + k) % 4]) w = (int'(mptr) + k) % 4;
    mptr = 2'(w + 1);
    sb_q.push_back({4'(1 << w), alu(a[w*W +: W], b[w*W +: W], s[2*w +: 2])});
    @(posedge clk); #1;
    chk("gnt_exec", 32'(gnt), 32'(1 << w));
    chk("busy_exec", 32'(busy), 32'd1);
    req = r & ~4'(1 << w); op_a = $urandom; op_b = $urandom; op_sel = 8'($urandom);
    @(posedge clk); #1;
    chk("gnt_resp", 32'(gnt), 32'(1 << w));
    chk("busy_resp", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("gnt_idle", 32'(gnt), 32'd0);
    chk("done_idle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    n_ops++;
  endtask

  task automatic pulse_rst();
    rst = 1; #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge clk); rst = 0;
    mptr = '0; n_ops = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_gnt", 32'(gnt), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_result", 32'(result), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    rst = 0;
    @(posedge clk); #1;
    issue(4'b0001, 32'h000000F0, 32'h0000003C, 8'h00);
    issue(4'b0100, 32'h00F00000, 32'h003C0000, 8'h10);
    issue(4'b0100, 32'h00F00000, 32'h003C0000, 8'h20);
    issue(4'b0100, 32'h00F00000, 32'h003C0000, 8'h30);
    issue(4'b0010, 32'h0000A500, 32'h00000F00, 8'h08);
    issue(4'b0011, 32'h00001234, 32'h0000FF0F, 8'h06);
    issue(4'b0010, 32'h00001234, 32'h0000FF0F, 8'h06);
    req = '0; @(negedge clk);
    pulse_rst();
    @(posedge clk); #1;
    issue(4'b1111, 32'h11223344, 32'hF0F0F0F0, 8'hE4);
    issue(4'b1110, 32'h11223344, 32'hF0F0F0F0, 8'hE4);
    issue(4'b1100, 32'h11223344, 32'hF0F0F0F0, 8'hE4);
    issue(4'b1000, 32'h11223344, 32'hF0F0F0F0, 8'hE4);
    for (int i = 0; i < 10; i++)
      issue(4'($urandom_range(1, 15)), $urandom, $urandom, 8'($urandom));
    issue(4'b0001, 32'h000000F0, 32'h0000003C, 8'h00);
    req = 4'b0100; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; op_sel = 8'h00;
    @(posedge clk); #1;
    chk("abort_gnt_exec", 32'(gnt), 32'h4);
    pulse_rst();
    @(posedge clk); #1;
    chk("abort_no_done", 32'(done), 32'd0);
    issue(4'b1010, 32'h0000C300, 32'h00005A00, 8'h04);
    issue(4'b1000, 32'hF0000000, 32'h3C000000, 8'hC0);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef LOGIC_ARB_STATS_EN
    chk("op_cnt", 32'(op_cnt), 32'(n_ops));
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
